sp_ram_arbiter: RTL and testbench

SP_RAM_ARBITER -- requirements
Module: sp_ram_arbiter

---
 rtl/sp_ram_arbiter.sv | 125 ++++++++++++
 tb/tb_sp_ram_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_arbiter.sv
// sp_ram_arbiter: two request ports share one single-port RAM with registered read.
// Round-robin grant from IDLE, sticky ownership while the owner keeps lock set,
// and a one-cycle read response routed back to the port that issued the read.
module sp_ram_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             p0_valid,
    output logic             p0_ready,
    input  logic             p0_we,
    input  logic             p0_lock,
    input  logic [AW-1:0]    p0_addr,
    input  logic [WIDTH-1:0] p0_wdata,
    output logic             p0_rvalid,
    output logic [WIDTH-1:0] p0_rdata,
    input  logic             p1_valid,
    output logic             p1_ready,
    input  logic             p1_we,
    input  logic             p1_lock,
    input  logic [AW-1:0]    p1_addr,
    input  logic [WIDTH-1:0] p1_wdata,
    output logic             p1_rvalid,
    output logic [WIDTH-1:0] p1_rdata,
    output logic             ram_ena,
    output logic             ram_wea,
    output logic [AW-1:0]    ram_addr,
    output logic [WIDTH-1:0] ram_din,
    input  logic [WIDTH-1:0] ram_dout
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t           state_reg, state_next;
    logic             last_grant_reg, last_grant_next;
    logic [1:0]       grant;
    logic [1:0]       valid;
    logic [1:0]       we;
    logic [1:0]       lock;
    logic             rvalid_reg [2];
    logic [WIDTH-1:0] rdata [2];

    assign valid = {p1_valid, p0_valid};
    assign we    = {p1_we, p0_we};
    assign lock  = {p1_lock, p0_lock};

    // State and round-robin history; reset leaves port 0 as the first contention winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
        end
    end

    // Grant decision and next state; grants are forced low while reset is held.
    always_comb begin
        grant           = 2'b00;
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        if (rst_n) begin
            case (state_reg)
                IDLE: begin
                    grant[0] = valid[0] & (~valid[1] | last_grant_reg);
                    grant[1] = valid[1] & (~valid[0] | ~last_grant_reg);
                end
                OWN0:    grant[0] = valid[0];
                OWN1:    grant[1] = valid[1];
                default: grant = 2'b00;
            endcase
        end
        if (grant[0]) begin
            last_grant_next = 1'b0;
            state_next      = lock[0] ? OWN0 : IDLE;
        end else if (grant[1]) begin
            last_grant_next = 1'b1;
            state_next      = lock[1] ? OWN1 : IDLE;
        end
    end

    assign p0_ready = grant[0];
    assign p1_ready = grant[1];
    assign ram_ena  = grant[0] | grant[1];

    // RAM request mux; everything is zero when nobody holds the grant.
    always_comb begin
        ram_wea  = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (grant[0]) begin
            ram_wea  = p0_we;
            ram_addr = p0_addr;
            ram_din  = p0_wdata;
        end else if (grant[1]) begin
            ram_wea  = p1_we;
            ram_addr = p1_addr;
            ram_din  = p1_wdata;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            // Read-beat tracker: the RAM output belongs to this port the cycle after its read.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rvalid_reg[gi] <= 1'b0;
                end else begin
                    rvalid_reg[gi] <= grant[gi] & ~we[gi];
                end
            end
            assign rdata[gi] = rvalid_reg[gi] ? ram_dout : '0;
        end
    endgenerate

    assign p0_rvalid = rvalid_reg[0];
    assign p1_rvalid = rvalid_reg[1];
    assign p0_rdata  = rdata[0];
    assign p1_rdata  = rdata[1];

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Bench for sp_ram_arbiter: vector table for arbitration from reset, hand-written
// multi-cycle sequences, then randomized traffic against an ownership/queue model.
module tb_sp_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       p0_valid, p0_we, p0_lock, p1_valid, p1_we, p1_lock;
    logic [7:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic       p0_ready, p1_ready, p0_rvalid, p1_rvalid;
    logic [7:0] p0_rdata, p1_rdata;
    logic       ram_ena, ram_wea;
    logic [7:0] ram_addr, ram_din;
    logic [7:0] ram_dout;
    logic [7:0] mem [256];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sp_ram_arbiter #(.WIDTH(8), .DEPTH(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_lock(p0_lock),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_lock(p1_lock),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    // Single-port RAM with registered read output
    always @(posedge clk) begin
        if (ram_ena) begin
            if (ram_wea) mem[ram_addr] <= ram_din;
            else         ram_dout <= mem[ram_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic we0, input logic lk0,
                         input logic [7:0] a0, input logic [7:0] d0,
                         input logic v1, input logic we1, input logic lk1,
                         input logic [7:0] a1, input logic [7:0] d1);
        p0_valid = v0; p0_we = we0; p0_lock = lk0; p0_addr = a0; p0_wdata = d0;
        p1_valid = v1; p1_we = we1; p1_lock = lk1; p1_addr = a1; p1_wdata = d1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    endtask

    typedef struct {
        logic v0, we0, lk0; logic [7:0] a0, d0;
        logic v1, we1, lk1; logic [7:0] a1, d1;
        logic er0, er1;
    } vec_t;

    vec_t vt [11];

    // Random-phase model state
    logic [7:0] shadow [256];
    int         owner, lg, g;
    logic       exp_rv [2];
    logic [7:0] exp_rd [2];

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'h00;
            shadow[i] = 8'h00;
        end
        ram_dout = 8'h00;

        // Arbitration table from reset: p0 writes 0x10<-0x11, p1 writes 0x20<-0x22
        //           v0 we lk a0     d0     v1 we lk a1     d1     r0 r1
        vt[0]  = '{1, 1, 0, 8'h10, 8'h11, 1, 1, 0, 8'h20, 8'h22, 1, 0};
        vt[1]  = '{1, 1, 0, 8'h10, 8'h11, 1, 1, 0, 8'h20, 8'h22, 0, 1};
        vt[2]  = '{1, 1, 0, 8'h10, 8'h11, 1, 1, 0, 8'h20, 8'h22, 1, 0};
        vt[3]  = '{1, 1, 0, 8'h10, 8'h11, 1, 1, 0, 8'h20, 8'h22, 0, 1};
        vt[4]  = '{0, 1, 0, 8'h10, 8'h11, 1, 1, 0, 8'h20, 8'h22, 0, 1};
        vt[5]  = '{1, 1, 0, 8'h10, 8'h11, 0, 1, 0, 8'h20, 8'h22, 1, 0};
        vt[6]  = '{0, 1, 0, 8'h10, 8'h11, 0, 1, 0, 8'h20, 8'h22, 0, 0};
        vt[7]  = '{1, 1, 0, 8'h10, 8'h11, 1, 1, 0, 8'h20, 8'h22, 0, 1};
        vt[8]  = '{1, 1, 1, 8'h10, 8'h11, 1, 1, 0, 8'h20, 8'h22, 1, 0};
        vt[9]  = '{1, 1, 0, 8'h10, 8'h11, 1, 1, 0, 8'h20, 8'h22, 1, 0};
        vt[10] = '{1, 1, 0, 8'h10, 8'h11, 1, 1, 0, 8'h20, 8'h22, 0, 1};

        // Reset with both ports requesting
        rst_n = 1'b0;
        drive(1, 0, 1, 8'h01, 8'h00, 1, 0, 1, 8'h02, 8'h00);
        tick(); tick(); #3;
        chk("rst_p0_ready", p0_ready, 0);
        chk("rst_p1_ready", p1_ready, 0);
        chk("rst_ram_ena", ram_ena, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_p0_rvalid", p0_rvalid, 0);
        chk("rst_p1_rvalid", p1_rvalid, 0);
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            drive(vt[i].v0, vt[i].we0, vt[i].lk0, vt[i].a0, vt[i].d0,
                  vt[i].v1, vt[i].we1, vt[i].lk1, vt[i].a1, vt[i].d1);
            #3;
            chk($sformatf("vec%0d_p0_ready", i), p0_ready, vt[i].er0);
            chk($sformatf("vec%0d_p1_ready", i), p1_ready, vt[i].er1);
            chk($sformatf("vec%0d_ram_ena", i), ram_ena, vt[i].er0 | vt[i].er1);
            chk($sformatf("vec%0d_ram_addr", i), ram_addr,
                vt[i].er0 ? vt[i].a0 : (vt[i].er1 ? vt[i].a1 : 8'h00));
            chk($sformatf("vec%0d_ram_din", i), ram_din,
                vt[i].er0 ? vt[i].d0 : (vt[i].er1 ? vt[i].d1 : 8'h00));
            tick();
        end
        idle();
        #3;
        chk("contention_mem10", mem[8'h10], 8'h11);
        chk("contention_mem20", mem[8'h20], 8'h22);
        chk("write_no_rvalid0", p0_rvalid, 0);
        chk("write_no_rvalid1", p1_rvalid, 0);
        tick();

        // Read latency: p1 writes 0xA5 at 0x05, p0 reads it back
        drive(0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h05, 8'hA5);
        #3; chk("lat_p1_wr_ready", p1_ready, 1); tick();
        drive(1, 0, 0, 8'h05, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        #3; chk("lat_p0_rd_ready", p0_ready, 1);
        chk("lat_ram_wea", ram_wea, 0);
        chk("lat_rvalid_early", p0_rvalid, 0); tick();
        idle();
        #3;
        chk("lat_p0_rvalid", p0_rvalid, 1);
        chk("lat_p0_rdata", p0_rdata, 8'hA5);
        chk("lat_p1_rvalid", p1_rvalid, 0);
        chk("lat_p1_rdata", p1_rdata, 0);
        tick(); #3;
        chk("lat_p0_rvalid_once", p0_rvalid, 0);
        chk("lat_p0_rdata_zero", p0_rdata, 0);
        tick();

        // Lock burst: make p1 the last grantee, then p0 bursts with lock 1,1,1,0
        drive(0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h30, 8'h33);
        #3; chk("burst_pre_p1", p1_ready, 1); tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, (i < 3), 8'h40 + 8'(i), 8'h50 + 8'(i), 1, 1, 0, 8'h31, 8'h34);
            #3;
            chk($sformatf("burst%0d_p0_ready", i), p0_ready, 1);
            chk($sformatf("burst%0d_p1_ready", i), p1_ready, 0);
            tick();
        end
        #3;
        chk("burst_after_p1_ready", p1_ready, 1);
        chk("burst_after_p0_ready", p0_ready, 0);
        tick();

        // Locked idle: p0 takes ownership then goes quiet while p1 waits
        drive(1, 1, 1, 8'h60, 8'h61, 0, 0, 0, 8'h00, 8'h00);
        #3; chk("lkidle_take", p0_ready, 1); tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h62, 8'h63);
            #3;
            chk($sformatf("lkidle%0d_p1_ready", i), p1_ready, 0);
            chk($sformatf("lkidle%0d_ram_ena", i), ram_ena, 0);
            tick();
        end
        drive(1, 1, 0, 8'h64, 8'h65, 1, 1, 0, 8'h62, 8'h63);
        #3; chk("lkidle_release_p0", p0_ready, 1); chk("lkidle_release_p1", p1_ready, 0); tick();
        #3; chk("lkidle_p1_granted", p1_ready, 1); tick();

        // Back-to-back reads: preload 0..7 via p0, then p1 reads them with no gaps
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 0, 8'(i), 8'hC0 + 8'(i), 0, 0, 0, 8'h00, 8'h00);
            tick();
        end
        for (int i = 0; i < 9; i++) begin
            if (i < 8) drive(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'(i), 8'h00);
            else       idle();
            #3;
            if (i < 8) chk($sformatf("b2b%0d_p1_ready", i), p1_ready, 1);
            if (i > 0) begin
                chk($sformatf("b2b%0d_p1_rvalid", i), p1_rvalid, 1);
                chk($sformatf("b2b%0d_p1_rdata", i), p1_rdata, 8'hC0 + 8'(i - 1));
            end
            tick();
        end
        #3; chk("b2b_end_rvalid", p1_rvalid, 0);

        // Reset between a locked p1 read beat and its response
        drive(0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h03, 8'h00);
        #3; chk("rstmid_p1_ready", p1_ready, 1); tick();
        rst_n = 1'b0;
        drive(1, 1, 0, 8'h70, 8'h71, 1, 1, 0, 8'h72, 8'h73);
        #1;
        chk("rstmid_p1_rvalid", p1_rvalid, 0);
        chk("rstmid_p1_rdata", p1_rdata, 0);
        chk("rstmid_ram_ena", ram_ena, 0);
        tick(); #3;
        chk("rstmid_p1_rvalid_hold", p1_rvalid, 0);
        chk("rstmid_p0_ready", p0_ready, 0);
        tick();
        rst_n = 1'b1;
        #3;
        chk("rstmid_first_p0", p0_ready, 1);
        chk("rstmid_first_p1", p1_ready, 0);
        tick(); #3;
        chk("rstmid_no_rvalid", p1_rvalid, 0);
        tick();

        // Randomized traffic against the model, from a fresh reset
        rst_n = 1'b0;
        idle();
        tick();
        rst_n = 1'b1;
        owner = -1; lg = 1;
        exp_rv[0] = 0; exp_rv[1] = 0; exp_rd[0] = 0; exp_rd[1] = 0;
        for (int c = 0; c < 300; c++) begin
            logic       v [2], w [2], l [2];
            logic [7:0] a [2], d [2];
            for (int n = 0; n < 2; n++) begin
                v[n] = 1'($urandom_range(0, 1));
                w[n] = 1'($urandom_range(0, 1));
                l[n] = ($urandom_range(0, 3) == 0);
                a[n] = 8'h80 + 8'($urandom_range(0, 15));
                d[n] = 8'($urandom);
            end
            drive(v[0], w[0], l[0], a[0], d[0], v[1], w[1], l[1], a[1], d[1]);
            if (owner >= 0)         g = v[owner] ? owner : -1;
            else if (v[0] && v[1])  g = (lg == 1) ? 0 : 1;
            else if (v[0])          g = 0;
            else if (v[1])          g = 1;
            else                    g = -1;
            #3;
            chk($sformatf("rnd%0d_p0_ready", c), p0_ready, g == 0);
            chk($sformatf("rnd%0d_p1_ready", c), p1_ready, g == 1);
            chk($sformatf("rnd%0d_ram_ena", c), ram_ena, g >= 0);
            chk($sformatf("rnd%0d_ram_wea", c), ram_wea, (g >= 0) ? w[g] : 1'b0);
            chk($sformatf("rnd%0d_ram_addr", c), ram_addr, (g >= 0) ? a[g] : 8'h00);
            chk($sformatf("rnd%0d_ram_din", c), ram_din, (g >= 0) ? d[g] : 8'h00);
            chk($sformatf("rnd%0d_p0_rvalid", c), p0_rvalid, exp_rv[0]);
            chk($sformatf("rnd%0d_p1_rvalid", c), p1_rvalid, exp_rv[1]);
            chk($sformatf("rnd%0d_p0_rdata", c), p0_rdata, exp_rv[0] ? exp_rd[0] : 8'h00);
            chk($sformatf("rnd%0d_p1_rdata", c), p1_rdata, exp_rv[1] ? exp_rd[1] : 8'h00);
            tick();
            exp_rv[0] = 0; exp_rv[1] = 0;
            if (g >= 0) begin
                lg = g;
                owner = l[g] ? g : -1;
                if (w[g]) begin
                    shadow[a[g]] = d[g];
                end else begin
                    exp_rv[g] = 1;
                    exp_rd[g] = shadow[a[g]];
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
